fetch_sequencer: RTL and testbench

Instruction-fetch and issue sequencer that sits directly upstream of the load/store unit. It drives the shared instruction/data RAM address and the `working` enable, captures the fetched word one cycle later, and hands each instruction to the execute stage with a valid/ready handshake. It stalls on loads until the LSU reports completion, and it also passes the top-level program-load address through while the core is idle.

---
 rtl/core_pkg.sv | 26 ++
 rtl/sat_counter.sv | 22 ++
 rtl/fetch_sequencer.sv | 111 +++++++++++
 tb/tb_fetch_sequencer.sv | 384 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared types and constants for the instruction-fetch sequencer:
// FSM state encoding, opcode values and the opcode field position.
package core_pkg;

    localparam int ADDR_W = 9;

    localparam int OPC_HI = 31;
    localparam int OPC_LO = 26;

    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_HALT = 6'h3F;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_ISSUE,
        S_STALL,
        S_HALT
    } fetch_state_t;

    function automatic logic [5:0] opcode_of(input logic [31:0] word);
        return word[OPC_HI:OPC_LO];
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc && (count != {CNT_W{1'b1}})) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch/issue sequencer in front of the LSU: fetches a word, offers it to
// execute, stalls on loads until the LSU reports completion, stops on HALT.
module fetch_sequencer
    import core_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] load_addr,
    output logic [ADDR_W-1:0] fetch_addr,
    output logic              working,
    input  logic [31:0]       instr,
    output logic              issue_valid,
    input  logic              issue_ready,
    output logic [31:0]       issue_instr,
    output logic [ADDR_W-1:0] issue_pc,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              lw_done,
    output logic              halted,
    output logic [CNT_W-1:0]  retired,
    output fetch_state_t      state_dbg
);

    fetch_state_t      state;
    fetch_state_t      state_nx;
    logic [ADDR_W-1:0] pc;
    logic              restart;
    logic              capture;
    logic              accept;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Handshake: issue_valid rises with issue_instr/issue_pc already stable and
    // they stay untouched until the edge where issue_ready is sampled high;
    // that edge is the only transfer, and redirect is only looked at there.
    always_comb begin
        state_nx = state;
        restart  = 1'b0;
        capture  = 1'b0;
        accept   = 1'b0;
        case (state)
            S_IDLE, S_HALT: begin
                if (start) begin
                    state_nx = S_REQ;
                    restart  = 1'b1;
                end
            end
            S_REQ: state_nx = S_WAIT;
            S_WAIT: begin
                capture  = 1'b1;
                state_nx = (opcode_of(instr) == OP_HALT) ? S_HALT : S_ISSUE;
            end
            S_ISSUE: begin
                if (issue_ready) begin
                    accept   = 1'b1;
                    state_nx = (opcode_of(issue_instr) == OP_LW) ? S_STALL : S_REQ;
                end
            end
            S_STALL: begin
                if (lw_done) begin
                    state_nx = S_REQ;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc          <= '0;
            issue_instr <= '0;
            issue_pc    <= '0;
        end else begin
            if (restart) begin
                pc <= '0;
            end else if (accept) begin
                pc <= redirect ? redirect_pc : pc + ADDR_W'(1);
            end
            if (capture) begin
                issue_instr <= instr;
                issue_pc    <= pc;
            end
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_retired (
        .clock (clock),
        .reset (reset),
        .clear (restart),
        .inc   (accept),
        .count (retired)
    );

    // While idle the top level owns the RAM address for program loading.
    assign fetch_addr  = (state == S_IDLE) ? load_addr : pc;
    assign working     = (state == S_REQ) || (state == S_WAIT) ||
                         (state == S_ISSUE) || (state == S_STALL);
    assign issue_valid = (state == S_ISSUE);
    assign halted      = (state == S_HALT);
    assign state_dbg   = state;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed scenarios plus random traffic, checked
// every cycle against a behavioural model of the fetch/issue rules.
module tb_fetch_sequencer;
  import core_pkg::*;

  localparam int AW = ADDR_W;
  localparam int W  = AW + 32;

  logic          clock = 1'b0;
  logic          reset;
  logic          start;
  logic [AW-1:0] load_addr;
  logic [31:0]   instr;
  logic          issue_ready;
  logic          redirect;
  logic [AW-1:0] redirect_pc;
  logic          lw_done;

  logic [AW-1:0] fetch_addr,  fetch_addr_s;
  logic          working,     working_s;
  logic          issue_valid, issue_valid_s;
  logic [31:0]   issue_instr, issue_instr_s;
  logic [AW-1:0] issue_pc,    issue_pc_s;
  logic          halted,      halted_s;
  logic [15:0]   retired;
  logic [1:0]    retired_s;
  fetch_state_t  state_dbg,   state_dbg_s;

  logic [31:0]   mem [512];
  logic [W-1:0]  exp_q[$];
  logic [W-1:0]  obs_q[$];

  int total = 0;
  int bad   = 0;

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  fetch_sequencer #(.CNT_W(16)) dut (
    .clock(clock), .reset(reset), .start(start), .load_addr(load_addr),
    .fetch_addr(fetch_addr), .working(working), .instr(instr),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_instr(issue_instr), .issue_pc(issue_pc), .redirect(redirect),
    .redirect_pc(redirect_pc), .lw_done(lw_done), .halted(halted),
    .retired(retired), .state_dbg(state_dbg)
  );

  fetch_sequencer #(.CNT_W(2)) dut_s (
    .clock(clock), .reset(reset), .start(start), .load_addr(load_addr),
    .fetch_addr(fetch_addr_s), .working(working_s), .instr(instr),
    .issue_valid(issue_valid_s), .issue_ready(issue_ready),
    .issue_instr(issue_instr_s), .issue_pc(issue_pc_s), .redirect(redirect),
    .redirect_pc(redirect_pc), .lw_done(lw_done), .halted(halted_s),
    .retired(retired_s), .state_dbg(state_dbg_s)
  );

  // synchronous RAM: data for the address presented this cycle appears next cycle
  always @(posedge clock) instr <= mem[fetch_addr];

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] sat(input int c, input int w);
    int mx;
    mx = (1 << w) - 1;
    return (c > mx) ? 64'(mx) : 64'(c);
  endfunction

  function automatic logic [31:0] alu_word();
    logic [5:0] op;
    op = 6'($urandom_range(0, 62));
    if (op == OP_LW) op = 6'h01;
    return {op, 26'($urandom)};
  endfunction

  // ---------------- behavioural model ----------------
  // phase while running: 0 address out, 1 data back, 2 offered, 3 waiting on load
  bit            m_run   = 1'b0;
  bit            m_halt  = 1'b0;
  logic [AW-1:0] m_pc    = '0;
  int            m_cnt   = 0;
  int            m_phase = 0;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_run = 1'b0; m_halt = 1'b0; m_pc = '0; m_cnt = 0; m_phase = 0;
      exp_q.delete();
      obs_q.delete();
    end else if (!m_run) begin
      if (start) begin
        m_run = 1'b1; m_halt = 1'b0; m_pc = '0; m_cnt = 0; m_phase = 0;
      end
    end else begin
      case (m_phase)
        0: m_phase = 1;
        1: begin
          if (mem[m_pc][31:26] == OP_HALT) begin
            m_run = 1'b0;
            m_halt = 1'b1;
          end else begin
            m_phase = 2;
          end
        end
        2: begin
          if (issue_ready) begin
            exp_q.push_back({m_pc, mem[m_pc]});
            m_cnt++;
            m_phase = (mem[m_pc][31:26] == OP_LW) ? 3 : 0;
            m_pc = redirect ? redirect_pc : AW'((int'(m_pc) + 1) % (1 << AW));
          end
        end
        default: if (lw_done) m_phase = 0;
      endcase
    end
  end

  // records each handshake the DUT is about to complete on the next edge
  always @(negedge clock) begin
    #4;
    if (!reset && issue_valid && issue_ready) obs_q.push_back({issue_pc, issue_instr});
  end

  // ---------------- compare process ----------------
  always @(negedge clock) begin
    logic          ev;
    logic [AW-1:0] efa;
    #2;
    ev  = m_run && (m_phase == 2);
    efa = (m_run || m_halt) ? m_pc : load_addr;
    check("working", working, m_run);
    check("halted", halted, m_halt);
    check("fetch_addr", fetch_addr, efa);
    check("issue_valid", issue_valid, ev);
    check("retired", retired, sat(m_cnt, 16));
    check("state_dbg_halt", state_dbg == S_HALT, m_halt);
    check("s_working", working_s, m_run);
    check("s_halted", halted_s, m_halt);
    check("s_fetch_addr", fetch_addr_s, efa);
    check("s_issue_valid", issue_valid_s, ev);
    check("s_retired", retired_s, sat(m_cnt, 2));
    check("s_state_dbg_idle", state_dbg_s == S_IDLE, !m_run && !m_halt);
    if (ev) begin
      check("issue_pc", issue_pc, m_pc);
      check("issue_instr", issue_instr, mem[m_pc]);
      check("s_issue_pc", issue_pc_s, m_pc);
      check("s_issue_instr", issue_instr_s, mem[m_pc]);
    end
    while (exp_q.size() > 0 && obs_q.size() > 0)
      check("accepted", obs_q.pop_front(), exp_q.pop_front());
  end

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(negedge clock);
    #3;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic wait_offer(output logic [AW-1:0] pc, output int waited);
    waited = 0;
    while (!issue_valid && waited < 64) begin
      cyc();
      waited++;
    end
    check("offer_within_bound", waited < 64, 1'b1);
    pc = issue_pc;
  endtask

  task automatic accept(input logic rd, input logic [AW-1:0] rpc);
    issue_ready = 1'b1;
    redirect    = rd;
    redirect_pc = rpc;
    cyc();
    issue_ready = 1'b0;
    redirect    = 1'b0;
  endtask

  task automatic run_to_halt();
    int n;
    n = 0;
    issue_ready = 1'b1;
    while (!halted && n < 300) begin
      cyc();
      n++;
    end
    issue_ready = 1'b0;
    check("halt_reached", halted, 1'b1);
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 512; i++) mem[i] = alu_word();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [AW-1:0] pc;
    int            w;
    int            seen;
    int            last;
    logic [31:0]   held;

    reset = 1'b1; start = 1'b0; load_addr = '0; issue_ready = 1'b0;
    redirect = 1'b0; redirect_pc = '0; lw_done = 1'b0;
    clear_mem();
    repeat (3) cyc();
    check("rst_retired", retired, 16'd0);
    check("rst_issue_valid", issue_valid, 1'b0);
    check("rst_working", working, 1'b0);
    check("rst_halted", halted, 1'b0);
    reset = 1'b0;
    cyc();

    // reset while an instruction is being offered
    mem[0] = alu_word();
    pulse_start();
    wait_offer(pc, w);
    check("pre_reset_valid", issue_valid, 1'b1);
    reset = 1'b1;
    #1;
    check("mid_reset_valid", issue_valid, 1'b0);
    check("mid_reset_working", working, 1'b0);
    load_addr = 9'h1A5;
    #1;
    check("idle_passthrough", fetch_addr, 9'h1A5);
    cyc();
    reset = 1'b0;
    repeat (2) cyc();
    check("post_reset_no_issue", issue_valid, 1'b0);

    // straight-line program, execute always ready
    mem[0] = alu_word(); mem[1] = alu_word(); mem[2] = alu_word();
    mem[3] = {OP_HALT, 26'h0};
    pulse_start();
    issue_ready = 1'b1;
    seen = 0;
    last = 0;
    for (int t = 0; t < 40 && !halted; t++) begin
      cyc();
      if (issue_valid) begin
        check("sl_pc", issue_pc, seen);
        if (seen > 0) check("sl_gap", t - last, 3);
        last = t;
        seen++;
      end
    end
    issue_ready = 1'b0;
    check("sl_count", seen, 3);
    check("sl_halted", halted, 1'b1);
    check("sl_retired", retired, 16'd3);
    check("sl_retired_sat", retired_s, 2'd3);

    // backpressure on pc 5
    for (int i = 0; i < 10; i++) mem[i] = alu_word();
    mem[10] = {OP_HALT, 26'h0};
    pulse_start();
    for (int i = 0; i < 5; i++) begin
      wait_offer(pc, w);
      accept(1'b0, '0);
    end
    wait_offer(pc, w);
    check("bp_pc", pc, 9'd5);
    held = issue_instr;
    for (int i = 0; i < 4; i++) begin
      cyc();
      check("bp_valid", issue_valid, 1'b1);
      check("bp_pc_hold", issue_pc, 9'd5);
      check("bp_instr_hold", issue_instr, held);
      check("bp_fetch_addr", fetch_addr, 9'd5);
      check("bp_retired", retired, 16'd5);
    end
    accept(1'b0, '0);
    check("bp_retired_after", retired, 16'd6);
    run_to_halt();

    // load stall at pc 2, lw_done five cycles after acceptance
    mem[0] = alu_word(); mem[1] = alu_word();
    mem[2] = {OP_LW, 26'($urandom)};
    mem[3] = alu_word(); mem[4] = {OP_HALT, 26'h0};
    pulse_start();
    for (int i = 0; i < 2; i++) begin
      wait_offer(pc, w);
      accept(1'b0, '0);
    end
    wait_offer(pc, w);
    check("lw_pc", pc, 9'd2);
    accept(1'b0, '0);
    for (int i = 0; i < 4; i++) begin
      check("lw_stall_valid", issue_valid, 1'b0);
      check("lw_stall_working", working, 1'b1);
      cyc();
    end
    lw_done = 1'b1;
    cyc();
    lw_done = 1'b0;
    wait_offer(pc, w);
    check("lw_resume_latency", w, 2);
    check("lw_resume_pc", pc, 9'd3);
    run_to_halt();

    // redirect to the top of memory and wrap
    mem[0] = alu_word(); mem[1] = alu_word(); mem[2] = {OP_HALT, 26'h0};
    mem[9'h1FF] = alu_word();
    pulse_start();
    redirect = 1'b1;
    redirect_pc = 9'h100;
    cyc();
    redirect = 1'b0;
    wait_offer(pc, w);
    check("rd_ignored_outside", pc, 9'd0);
    redirect = 1'b1;
    cyc();
    redirect = 1'b0;
    check("rd_ignored_unready", issue_pc, 9'd0);
    accept(1'b1, 9'h1FF);
    wait_offer(pc, w);
    check("rd_target", pc, 9'h1FF);
    accept(1'b0, '0);
    wait_offer(pc, w);
    check("rd_wrap", pc, 9'h000);
    accept(1'b0, '0);
    wait_offer(pc, w);
    check("rd_after_wrap", pc, 9'd1);
    accept(1'b0, '0);
    run_to_halt();
    check("rd_retired", retired, 16'd4);

    // restart from halt, start ignored while running, counter saturation
    for (int i = 0; i < 6; i++) mem[i] = alu_word();
    mem[6] = {OP_HALT, 26'h0};
    pulse_start();
    check("rs_retired_clear", retired, 16'd0);
    check("rs_halted_clear", halted, 1'b0);
    wait_offer(pc, w);
    check("rs_first_pc", pc, 9'd0);
    accept(1'b0, '0);
    pulse_start();
    wait_offer(pc, w);
    check("rs_start_ignored", pc, 9'd1);
    for (int i = 0; i < 4; i++) begin
      wait_offer(pc, w);
      accept(1'b0, '0);
    end
    check("sat_wide", retired, 16'd5);
    check("sat_narrow", retired_s, 2'd3);
    run_to_halt();

    // random traffic over a random program
    for (int i = 0; i < 512; i++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 4)       mem[i] = {OP_HALT, 26'($urandom)};
      else if (r < 20) mem[i] = {OP_LW, 26'($urandom)};
      else             mem[i] = alu_word();
    end
    for (int i = 0; i < 4000; i++) begin
      start       = ($urandom_range(0, 29) == 0);
      issue_ready = 1'($urandom_range(0, 1));
      redirect    = ($urandom_range(0, 4) == 0);
      redirect_pc = AW'($urandom_range(0, 511));
      lw_done     = ($urandom_range(0, 3) == 0);
      load_addr   = AW'($urandom_range(0, 511));
      reset       = ($urandom_range(0, 599) == 0);
      cyc();
    end
    reset = 1'b0; start = 1'b0; issue_ready = 1'b0; redirect = 1'b0; lw_done = 1'b0;
    repeat (3) cyc();
    check("handshake_queue_balance", exp_q.size(), obs_q.size());

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
